pc_seq: RTL and testbench

- Parametrised successor to the program-counter and link-register pair. Combines the PC, the jump-target selection and a multi-level return-address stack in one sequential block.
- Supports nested CALL/RET to a configurable depth, relative jumps, conditional jumps, halt and stall. Stack overflow and underflow are detected.
- Sits between the instruction decoder and the ROM address input; pc drives the ROM address directly.

---
 rtl/pc_seq_pkg.sv | 16 +
 rtl/pc_seq_ret_stack.sv | 64 ++++++
 rtl/pc_seq.sv | 109 ++++++++++
 tb/tb_pc_seq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: operation encodings
// and the width of the op field.
package pc_seq_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_NEXT     = 3'd0;
   localparam logic [OP_W-1:0] OP_JMP      = 3'd1;
   localparam logic [OP_W-1:0] OP_JREL     = 3'd2;
   localparam logic [OP_W-1:0] OP_JCOND    = 3'd3;
   localparam logic [OP_W-1:0] OP_CALL     = 3'd4;
   localparam logic [OP_W-1:0] OP_RET      = 3'd5;
   localparam logic [OP_W-1:0] OP_HALT     = 3'd6;
   localparam logic [OP_W-1:0] OP_SOFT_RST = 3'd7;

endpackage

// File: rtl/pc_seq_ret_stack.sv
// Return-address stack: a LIFO of WIDTH-bit entries with a registered depth
// count. Push on full and pop on empty are ignored here; the caller flags them.
module ret_stack #(
   parameter  int WIDTH       = 8,
   parameter  int STACK_DEPTH = 4,
   localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [SP_W-1:0]  depth,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [STACK_DEPTH];
   logic [WIDTH-1:0] mem_d [STACK_DEPTH];
   logic [SP_W-1:0]  depth_q;
   logic [SP_W-1:0]  depth_d;

   assign depth = depth_q;
   assign full  = (depth_q == SP_W'(STACK_DEPTH));
   assign empty = (depth_q == {SP_W{1'b0}});

   // Next-state of the entries, the depth count and the top-of-stack read
   always_comb begin
      mem_d   = mem_q;
      depth_d = depth_q;
      dout    = {WIDTH{1'b0}};
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (push && !full && (depth_q == SP_W'(i))) begin
            mem_d[i] = din;
         end else begin
            mem_d[i] = mem_q[i];
         end
         dout = (depth_q == SP_W'(i + 1)) ? mem_q[i] : dout;
      end
      if (push && !full) begin
         depth_d = depth_q + {{(SP_W-1){1'b0}}, 1'b1};
      end else if (pop && !empty) begin
         depth_d = depth_q - {{(SP_W-1){1'b0}}, 1'b1};
      end else begin
         depth_d = depth_q;
      end
   end

   // Depth register; only the count needs a reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         depth_q <= {SP_W{1'b0}};
      end else begin
         depth_q <= depth_d;
      end
   end

   // Entry storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/pc_seq.sv
// Program counter with jump-target selection and a nested return-address
// stack; pc feeds the ROM address directly.
module pc_seq
   import pc_seq_pkg::*;
#(
   parameter  int               WIDTH       = 8,
   parameter  int               STACK_DEPTH = 4,
   parameter  logic [WIDTH-1:0] RST_ADDR    = '0,
   localparam int               SP_W        = $clog2(STACK_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic [OP_W-1:0]  op,
   input  logic             cond,
   input  logic [WIDTH-1:0] target,
   input  logic [WIDTH-1:0] offset,
   output logic [WIDTH-1:0] pc,
   output logic [SP_W-1:0]  depth,
   output logic             stack_full,
   output logic             stack_empty,
   output logic             stack_err
);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] pc_inc_s;
   logic [WIDTH-1:0] top_s;
   logic             push_s, pop_s, soft_s, stack_rst_s;

   assign pc        = pc_q;
   assign stack_err = err_q;
   assign pc_inc_s  = pc_q + {{(WIDTH-1){1'b0}}, 1'b1};

   // SOFT_RST clears the stack depth through its synchronous reset
   assign stack_rst_s = rst & ~soft_s;

   ret_stack #(
      .WIDTH       (WIDTH),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk   (clk),
      .rst   (stack_rst_s),
      .push  (push_s),
      .pop   (pop_s),
      .din   (pc_inc_s),
      .dout  (top_s),
      .depth (depth),
      .full  (stack_full),
      .empty (stack_empty)
   );

   // Op decode: next pc, error flag and stack control
   always_comb begin
      pc_d   = pc_q;
      err_d  = err_q;
      push_s = 1'b0;
      pop_s  = 1'b0;
      soft_s = 1'b0;
      if (stall) begin
         pc_d  = pc_q;
         err_d = err_q;
      end else begin
         case (op)
            OP_NEXT:  pc_d = pc_inc_s;
            OP_JMP:   pc_d = target;
            OP_JREL:  pc_d = pc_q + offset;
            OP_JCOND: pc_d = cond ? target : pc_inc_s;
            OP_CALL: begin
               if (!stack_full) begin
                  push_s = 1'b1;
                  pc_d   = target;
               end else begin
                  pc_d  = pc_inc_s;
                  err_d = 1'b1;
               end
            end
            OP_RET: begin
               if (!stack_empty) begin
                  pop_s = 1'b1;
                  pc_d  = top_s;
               end else begin
                  pc_d  = pc_inc_s;
                  err_d = 1'b1;
               end
            end
            OP_HALT: pc_d = pc_q;
            OP_SOFT_RST: begin
               soft_s = 1'b1;
               pc_d   = RST_ADDR;
               err_d  = 1'b0;
            end
            default: pc_d = pc_q;
         endcase
      end
   end

   // pc and sticky error registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q  <= RST_ADDR;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         err_q <= err_d;
      end
   end

endmodule

// File: tb/tb_pc_seq.sv
// Directed table-driven bench for pc_seq (WIDTH=8, STACK_DEPTH=4, RST_ADDR=0)
// plus a model-tracked fill/drain sequence of the return stack.
module tb_pc_seq;

   logic       clk = 1'b0;
   logic       rst, stall, cond;
   logic [2:0] op;
   logic [7:0] target, offset;
   logic [7:0] pc;
   logic [2:0] depth;
   logic       stack_full, stack_empty, stack_err;

   int n_vec = 0;
   int n_bad = 0;

   localparam logic [2:0] NXT = 3'd0, JMP = 3'd1, JRL = 3'd2, JCD = 3'd3,
                          CAL = 3'd4, RET = 3'd5, HLT = 3'd6, SRS = 3'd7;

   typedef struct {
      string      name;
      logic       rst;
      logic       stall;
      logic [2:0] op;
      logic       cond;
      logic [7:0] tgt;
      logic [7:0] off;
      logic [7:0] e_pc;
      logic [2:0] e_dep;
      logic       e_full;
      logic       e_empty;
      logic       e_err;
   } vec_t;

   vec_t tv[$];

   pc_seq #(.WIDTH(8), .STACK_DEPTH(4), .RST_ADDR(8'h00)) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .op          (op),
      .cond        (cond),
      .target      (target),
      .offset      (offset),
      .pc          (pc),
      .depth       (depth),
      .stack_full  (stack_full),
      .stack_empty (stack_empty),
      .stack_err   (stack_err)
   );

   always #5 clk = ~clk;

   task automatic add(input string nm, input logic r, input logic s, input logic [2:0] o,
                      input logic c, input logic [7:0] t, input logic [7:0] f,
                      input logic [7:0] ep, input logic [2:0] ed, input logic ee);
      vec_t v;
      v.name = nm; v.rst = r; v.stall = s; v.op = o; v.cond = c; v.tgt = t; v.off = f;
      v.e_pc = ep; v.e_dep = ed; v.e_err = ee;
      v.e_full  = (ed == 3'd4);
      v.e_empty = (ed == 3'd0);
      tv.push_back(v);
   endtask

   task automatic step(input logic r, input logic s, input logic [2:0] o,
                       input logic c, input logic [7:0] t, input logic [7:0] f);
      rst = r; stall = s; op = o; cond = c; target = t; offset = f;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [7:0] ep, input logic [2:0] ed,
                        input logic ef, input logic em, input logic ee);
      n_vec++;
      if (pc !== ep || depth !== ed || stack_full !== ef || stack_empty !== em || stack_err !== ee) begin
         n_bad++;
         $display("FAIL %s: got pc=%h depth=%0d full=%b empty=%b err=%b, expected pc=%h depth=%0d full=%b empty=%b err=%b",
                  nm, pc, depth, stack_full, stack_empty, stack_err, ep, ed, ef, em, ee);
      end
   endtask

   logic [7:0] m_pc;
   logic [7:0] m_stk[$];

   initial begin
      rst = 1'b0; stall = 1'b0; op = NXT; cond = 1'b0; target = 8'h00; offset = 8'h00;

      //   name          rst   stall op   cond  target offset  pc     dep   err
      add("reset",       1'b0, 1'b0, NXT, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);
      add("next1",       1'b1, 1'b0, NXT, 1'b0, 8'h00, 8'h00, 8'h01, 3'd0, 1'b0);
      add("next2",       1'b1, 1'b0, NXT, 1'b0, 8'h00, 8'h00, 8'h02, 3'd0, 1'b0);
      add("next3",       1'b1, 1'b0, NXT, 1'b0, 8'h00, 8'h00, 8'h03, 3'd0, 1'b0);
      add("jmp_fe",      1'b1, 1'b0, JMP, 1'b0, 8'hFE, 8'h00, 8'hFE, 3'd0, 1'b0);
      add("next_ff",     1'b1, 1'b0, NXT, 1'b0, 8'h00, 8'h00, 8'hFF, 3'd0, 1'b0);
      add("next_wrap",   1'b1, 1'b0, NXT, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);
      add("jmp_10",      1'b1, 1'b0, JMP, 1'b0, 8'h10, 8'h00, 8'h10, 3'd0, 1'b0);
      add("jrel_neg",    1'b1, 1'b0, JRL, 1'b0, 8'h00, 8'hFC, 8'h0C, 3'd0, 1'b0);
      add("jmp_f0",      1'b1, 1'b0, JMP, 1'b0, 8'hF0, 8'h00, 8'hF0, 3'd0, 1'b0);
      add("jrel_wrap",   1'b1, 1'b0, JRL, 1'b0, 8'h00, 8'h20, 8'h10, 3'd0, 1'b0);
      add("jmp_05",      1'b1, 1'b0, JMP, 1'b0, 8'h05, 8'h00, 8'h05, 3'd0, 1'b0);
      add("call_20",     1'b1, 1'b0, CAL, 1'b0, 8'h20, 8'h00, 8'h20, 3'd1, 1'b0);
      add("next_21",     1'b1, 1'b0, NXT, 1'b0, 8'h00, 8'h00, 8'h21, 3'd1, 1'b0);
      add("call_40",     1'b1, 1'b0, CAL, 1'b0, 8'h40, 8'h00, 8'h40, 3'd2, 1'b0);
      add("ret_22",      1'b1, 1'b0, RET, 1'b0, 8'h00, 8'h00, 8'h22, 3'd1, 1'b0);
      add("ret_06",      1'b1, 1'b0, RET, 1'b0, 8'h00, 8'h00, 8'h06, 3'd0, 1'b0);
      add("ovf_call1",   1'b1, 1'b0, CAL, 1'b0, 8'h50, 8'h00, 8'h50, 3'd1, 1'b0);
      add("ovf_call2",   1'b1, 1'b0, CAL, 1'b0, 8'h60, 8'h00, 8'h60, 3'd2, 1'b0);
      add("ovf_call3",   1'b1, 1'b0, CAL, 1'b0, 8'h70, 8'h00, 8'h70, 3'd3, 1'b0);
      add("ovf_call4",   1'b1, 1'b0, CAL, 1'b0, 8'h30, 8'h00, 8'h30, 3'd4, 1'b0);
      add("ovf_call5",   1'b1, 1'b0, CAL, 1'b0, 8'h90, 8'h00, 8'h31, 3'd4, 1'b1);
      add("drain_ret1",  1'b1, 1'b0, RET, 1'b0, 8'h00, 8'h00, 8'h71, 3'd3, 1'b1);
      add("drain_ret2",  1'b1, 1'b0, RET, 1'b0, 8'h00, 8'h00, 8'h61, 3'd2, 1'b1);
      add("drain_ret3",  1'b1, 1'b0, RET, 1'b0, 8'h00, 8'h00, 8'h51, 3'd1, 1'b1);
      add("drain_ret4",  1'b1, 1'b0, RET, 1'b0, 8'h00, 8'h00, 8'h07, 3'd0, 1'b1);
      add("unf_ret",     1'b1, 1'b0, RET, 1'b0, 8'h00, 8'h00, 8'h08, 3'd0, 1'b1);
      add("halt",        1'b1, 1'b0, HLT, 1'b0, 8'h00, 8'h00, 8'h08, 3'd0, 1'b1);
      add("soft_rst",    1'b1, 1'b0, SRS, 1'b0, 8'h55, 8'h00, 8'h00, 3'd0, 1'b0);
      add("jmp_10b",     1'b1, 1'b0, JMP, 1'b0, 8'h10, 8'h00, 8'h10, 3'd0, 1'b0);
      add("jcond_0",     1'b1, 1'b0, JCD, 1'b0, 8'h80, 8'h00, 8'h11, 3'd0, 1'b0);
      add("jcond_1",     1'b1, 1'b0, JCD, 1'b1, 8'h80, 8'h00, 8'h80, 3'd0, 1'b0);
      add("st_call_20",  1'b1, 1'b0, CAL, 1'b0, 8'h20, 8'h00, 8'h20, 3'd1, 1'b0);
      add("st_call_40",  1'b1, 1'b0, CAL, 1'b0, 8'h40, 8'h00, 8'h40, 3'd2, 1'b0);
      add("stall1",      1'b1, 1'b1, CAL, 1'b0, 8'hA0, 8'h00, 8'h40, 3'd2, 1'b0);
      add("stall2",      1'b1, 1'b1, CAL, 1'b0, 8'hA0, 8'h00, 8'h40, 3'd2, 1'b0);
      add("post_stall",  1'b1, 1'b0, RET, 1'b0, 8'h00, 8'h00, 8'h21, 3'd1, 1'b0);
      add("call_again",  1'b1, 1'b0, CAL, 1'b0, 8'h40, 8'h00, 8'h40, 3'd2, 1'b0);
      add("rst_prio",    1'b0, 1'b1, CAL, 1'b0, 8'hA0, 8'h00, 8'h00, 3'd0, 1'b0);
      add("err_set",     1'b1, 1'b0, RET, 1'b0, 8'h00, 8'h00, 8'h01, 3'd0, 1'b1);
      add("stall_srst",  1'b1, 1'b1, SRS, 1'b0, 8'h00, 8'h00, 8'h01, 3'd0, 1'b1);
      add("err_sticky",  1'b1, 1'b0, NXT, 1'b0, 8'h00, 8'h00, 8'h02, 3'd0, 1'b1);

      for (int i = 0; i < tv.size(); i++) begin
         step(tv[i].rst, tv[i].stall, tv[i].op, tv[i].cond, tv[i].tgt, tv[i].off);
         check(tv[i].name, tv[i].e_pc, tv[i].e_dep, tv[i].e_full, tv[i].e_empty, tv[i].e_err);
      end

      // Fill the stack to the boundary, overflow once, then drain past empty
      step(1'b1, 1'b0, SRS, 1'b0, 8'h00, 8'h00);
      m_pc = 8'h00;
      check("seq_srst", m_pc, 3'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         logic [7:0] t;
         t = 8'hC0 + 8'(i * 9);
         step(1'b1, 1'b0, CAL, 1'b0, t, 8'h00);
         m_stk.push_back(m_pc + 8'h01);
         m_pc = t;
         check("seq_fill", m_pc, 3'(m_stk.size()), (i == 3), 1'b0, 1'b0);
      end
      step(1'b1, 1'b0, CAL, 1'b0, 8'h11, 8'h00);
      m_pc = m_pc + 8'h01;
      check("seq_over", m_pc, 3'd4, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, RET, 1'b0, 8'h00, 8'h00);
         m_pc = m_stk.pop_back();
         check("seq_drain", m_pc, 3'(m_stk.size()), 1'b0, (i == 3), 1'b1);
      end
      step(1'b1, 1'b0, RET, 1'b0, 8'h00, 8'h00);
      m_pc = m_pc + 8'h01;
      check("seq_under", m_pc, 3'd0, 1'b0, 1'b1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
